// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller: one shared round-key step, one round key per cycle.
// Optional 11-entry round-key store with indexed reads, enabled by defining KSCHED_STORE_EN.
module aes_key_sched_ctrl #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [0:KEY_W-1] key_in,
   input  logic             abort,
   output logic             busy,
   output logic             rk_valid,
   output logic [0:KEY_W-1] rk_out,
   output logic [3:0]       rk_round,
   output logic             done,
   input  logic [3:0]       rd_idx,
   output logic [0:KEY_W-1] rd_key,
   output logic             keys_valid
);

   localparam logic [3:0] LAST = 4'(NR);

   typedef enum logic {S_IDLE, S_EXPAND} state_t;

   state_t           state_q, state_d;
   logic [0:7]       rcon, rcon_d;
   logic             busy_d, rk_valid_d, done_d;
   logic [0:KEY_W-1] rk_out_d;
   logic [3:0]       rk_round_d;
   logic             accept;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), then the AES affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      inv  = gf_mul(x252, x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] key_step(input logic [0:127] k, input logic [0:7] rc);
      logic [0:31] w0, w1, w2, w3, rot, t, y0, y1, y2, y3;
      w0  = k[0:31];
      w1  = k[32:63];
      w2  = k[64:95];
      w3  = k[96:127];
      rot = {w3[8:31], w3[0:7]};
      t   = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])} ^ {rc, 24'h0};
      y0  = w0 ^ t;
      y1  = w1 ^ y0;
      y2  = w2 ^ y1;
      y3  = w3 ^ y2;
      return {y0, y1, y2, y3};
   endfunction

   assign key_ready = !busy;
   assign accept    = (state_q == S_IDLE) && key_valid && key_ready && !abort;

   always_comb begin
      state_d    = state_q;
      busy_d     = busy;
      rk_valid_d = rk_valid;
      rk_out_d   = rk_out;
      rk_round_d = rk_round;
      done_d     = done;
      rcon_d     = rcon;
      case (state_q)
         S_IDLE: begin
            busy_d     = 1'b0;
            rk_valid_d = 1'b0;
            done_d     = 1'b0;
            if (accept) begin
               state_d    = S_EXPAND;
               busy_d     = 1'b1;
               rk_valid_d = 1'b1;
               rk_out_d   = key_in;
               rk_round_d = 4'd0;
               rcon_d     = 8'h01;
            end
         end
         S_EXPAND: begin
            if (abort) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               rk_valid_d = 1'b0;
               done_d     = 1'b0;
               rk_round_d = 4'd0;
               rcon_d     = 8'h01;
            end else if (rk_round == LAST) begin
               // Final key has been presented; rk_out/rk_round hold it.
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               rk_valid_d = 1'b0;
               done_d     = 1'b0;
            end else begin
               rk_out_d   = key_step(rk_out, rcon);
               rk_round_d = rk_round + 4'd1;
               rcon_d     = {rcon[1:7], 1'b0} ^ (rcon[0] ? 8'h1B : 8'h00);
               done_d     = (rk_round == LAST - 4'd1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         rk_out   <= '0;
         rk_round <= 4'd0;
         done     <= 1'b0;
         rcon     <= 8'h01;
      end else begin
         state_q  <= state_d;
         busy     <= busy_d;
         rk_valid <= rk_valid_d;
         rk_out   <= rk_out_d;
         rk_round <= rk_round_d;
         done     <= done_d;
         rcon     <= rcon_d;
      end
   end

`ifdef KSCHED_STORE_EN
   logic [0:KEY_W-1] store [0:10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 11; i++) store[i] <= '0;
         rd_key     <= '0;
         keys_valid <= 1'b0;
      end else begin
         if (rk_valid) store[rk_round] <= rk_out;
         rd_key <= (rd_idx <= 4'd10) ? store[rd_idx] : '0;
         // Entries written before an abort survive, but never count as a complete set.
         if (accept || (abort && state_q == S_EXPAND)) keys_valid <= 1'b0;
         else if (done)                              keys_valid <= 1'b1;
      end
   end
`else
   logic unused_store_inputs;
   assign unused_store_inputs = ^{rd_idx, accept};
   assign rd_key              = '0;
   assign keys_valid          = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed testbench for aes_key_sched_ctrl: FIPS-197 and zero-key expansions, back-to-back
// offers, abort, mid-expansion reset and (with KSCHED_STORE_EN) the round-key store.
module tb_aes_key_sched_ctrl;

   localparam logic [0:127] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [0:127] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [0:127] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [0:127] ZERO_K   = 128'h0;
   localparam logic [0:127] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [0:127] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
   localparam logic [0:127] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [0:127] key_in;
   logic         abort;
   logic         busy;
   logic         rk_valid;
   logic [0:127] rk_out;
   logic [3:0]   rk_round;
   logic         done;
   logic [3:0]   rd_idx;
   logic [0:127] rd_key;
   logic         keys_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   aes_key_sched_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_in     (key_in),
      .abort      (abort),
      .busy       (busy),
      .rk_valid   (rk_valid),
      .rk_out     (rk_out),
      .rk_round   (rk_round),
      .done       (done),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key),
      .keys_valid (keys_valid)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " busy"}, 128'(busy), 128'(0));
      check({tag, " key_ready"}, 128'(key_ready), 128'(1));
      check({tag, " rk_valid"}, 128'(rk_valid), 128'(0));
      check({tag, " done"}, 128'(done), 128'(0));
   endtask

   // Offers k for one cycle (T), then checks T+1..T+11 and the idle cycle T+12.
   task automatic run_expansion(input string tag, input logic [0:127] k, input logic [0:127] r1,
                                input logic [0:127] r2, input logic [0:127] r10);
      key_valid = 1'b1;
      key_in    = k;
      step();
      key_valid = 1'b0;
      for (int r = 0; r <= 10; r++) begin
         check({tag, " rk_valid"}, 128'(rk_valid), 128'(1));
         check({tag, " rk_round"}, 128'(rk_round), 128'(r));
         check({tag, " busy"}, 128'(busy), 128'(1));
         check({tag, " key_ready"}, 128'(key_ready), 128'(0));
         check({tag, " done"}, 128'(done), 128'(r == 10));
         if (r == 0)  check({tag, " rk0"}, rk_out, k);
         if (r == 1)  check({tag, " rk1"}, rk_out, r1);
         if (r == 2)  check({tag, " rk2"}, rk_out, r2);
         if (r == 10) check({tag, " rk10"}, rk_out, r10);
         if (r < 10) step();
      end
      step();
      check_idle({tag, " end"});
      check({tag, " rk_out hold"}, rk_out, r10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      abort     = 1'b0;
      rd_idx    = 4'd0;
      step();
      step();
      check_idle("reset");
      check("reset rk_out", rk_out, 128'(0));
      check("reset rk_round", 128'(rk_round), 128'(0));
      check("reset rd_key", rd_key, 128'(0));
      check("reset keys_valid", 128'(keys_valid), 128'(0));
      rst_n = 1'b1;
      step();

      // FIPS-197 vector
      run_expansion("fips", FIPS_K, FIPS_R1, FIPS_R2, FIPS_R10);
`ifdef KSCHED_STORE_EN
      check("store keys_valid", 128'(keys_valid), 128'(1));
      rd_idx = 4'd0;
      step();
      check("store rd0", rd_key, FIPS_K);
      rd_idx = 4'd10;
      step();
      check("store rd10", rd_key, FIPS_R10);
      rd_idx = 4'd12;
      step();
      check("store rd12", rd_key, 128'(0));
      rd_idx = 4'd1;
      step();
      check("store rd1", rd_key, FIPS_R1);
`else
      rd_idx = 4'd10;
      step();
      check("nostore rd_key", rd_key, 128'(0));
      check("nostore keys_valid", 128'(keys_valid), 128'(0));
`endif

      // All-zero key
      run_expansion("zero", ZERO_K, ZERO_R1, ZERO_R2, ZERO_R10);

      // key_valid held high: second key must wait for T+12
      key_valid = 1'b1;
      key_in    = FIPS_K;
      step();
      key_in = ZERO_K;
      for (int r = 0; r <= 10; r++) begin
         check("hold key_ready", 128'(key_ready), 128'(0));
         check("hold rk_round", 128'(rk_round), 128'(r));
         if (r == 1)  check("hold rk1", rk_out, FIPS_R1);
         if (r == 10) check("hold rk10", rk_out, FIPS_R10);
         if (r < 10) step();
      end
      step();
      check("hold T12 key_ready", 128'(key_ready), 128'(1));
      check("hold T12 rk_valid", 128'(rk_valid), 128'(0));
      step();
      key_valid = 1'b0;
      check("hold 2nd busy", 128'(busy), 128'(1));
      check("hold 2nd rk_round", 128'(rk_round), 128'(0));
      check("hold 2nd rk0", rk_out, ZERO_K);
      step();
      check("hold 2nd rk1", rk_out, ZERO_R1);
      for (int i = 0; i < 9; i++) step();
      check("hold 2nd rk10", rk_out, ZERO_R10);
      check("hold 2nd done", 128'(done), 128'(1));
      step();
      check_idle("hold 2nd end");

      // abort at T+5, then abort beats a key offer in IDLE
      key_valid = 1'b1;
      key_in    = ZERO_K;
      step();
      key_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("abort T5 rk_round", 128'(rk_round), 128'(4));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_idle("abort T6");
`ifdef KSCHED_STORE_EN
      check("abort keys_valid", 128'(keys_valid), 128'(0));
`endif
      key_valid = 1'b1;
      key_in    = FIPS_K;
      abort     = 1'b1;
      step();
      abort     = 1'b0;
      key_valid = 1'b0;
      check("abort wins busy", 128'(busy), 128'(0));
      check("abort wins rk_valid", 128'(rk_valid), 128'(0));
      run_expansion("post-abort", FIPS_K, FIPS_R1, FIPS_R2, FIPS_R10);

      // asynchronous reset at T+3
      key_valid = 1'b1;
      key_in    = FIPS_K;
      step();
      key_valid = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async rst");
      check("async rst rk_out", rk_out, 128'(0));
      check("async rst rk_round", 128'(rk_round), 128'(0));
      check("async rst keys_valid", 128'(keys_valid), 128'(0));
      step();
      check("rst held done", 128'(done), 128'(0));
      rst_n = 1'b1;
      step();
      run_expansion("post-rst", ZERO_K, ZERO_R1, ZERO_R2, ZERO_R10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
